prog_counter_stack: RTL
=======================

# prog_counter_stack

Parametrised program counter for the 8-bit computer. It is the successor to the 4-bit counter and adds configurable address width, relative branching and a hardware call/return stack of configurable depth. The block drives the shared bus through a tri-state output and exposes stack status to the control unit so subroutine calls and returns execute in one clock.

## Interface
- WIDTH, 4: address width in bits (≥ 2).
- DEPTH, 4: return-stack entries (≥ 1).
- SPW, derived: $clog2(DEPTH+1), stack-pointer width.

- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  synchronous active-high reset/clear.
- in  in  WIDTH  jump target (absolute) or signed offset (relative).
- oe  in  1  output enable for `out`.
- jmp  in  1  load jump (absolute or relative per `rel`).
- rel  in  1  qualifies `jmp`: 1 = relative, 0 = absolute.
- call  in  1  push return address, then load `in` (absolute).
- ret  in  1  pop return address into counter.
- inc  in  1  increment counter.
- out  out  WIDTH  counter value when `oe`=1, else all-z.
- pc  out  WIDTH  counter value, always driven (control/debug).
- sp  out  SPW  number of valid stack entries.
- stk_full  out  1  sp == DEPTH.
- stk_empty  out  1  sp == 0.
- stk_err  out  1  sticky overflow/underflow flag.

## Operation
- State: counter `pc` (WIDTH), stack array DEPTH×WIDTH, pointer `sp` (SPW), sticky `stk_err`.
- Priority per edge, highest first: clr > jmp > call > ret > inc > hold. Only the winning command acts; lower commands in the same cycle are ignored entirely, with no push, pop or error.
- clr: pc←0, sp←0, stk_err←0. Stack contents are don't-care after clear.
- jmp, rel=0: pc←in.
- jmp, rel=1: pc←pc + sign-extended `in`, modulo 2^WIDTH. `in` is two's complement over WIDTH bits.
- call, not full: stack[sp]←pc+1 (mod 2^WIDTH), sp←sp+1, pc←in.
- call, full: pc, sp and stack unchanged; stk_err←1.
- ret, not empty: pc←stack[sp-1], sp←sp-1.
- ret, empty: pc and sp unchanged; stk_err←1.
- inc: pc←pc+1. From all-ones it wraps to 0 with no flag.
- stk_err stays set until clr. Later valid calls and returns still execute normally.
- out = oe ? pc : {WIDTH{z}}. This is combinational on `oe` and does not depend on clk.
- stk_full and stk_empty are combinational decodes of sp.

## Timing
- Reset values after an edge with clr=1: pc=0, sp=0, stk_empty=1, stk_full=0, stk_err=0, out=0 if oe else z.
- Every command has a latency of 1: the new pc is visible on `pc`/`out` immediately after the edge that samples it.
- call and ret each complete in a single cycle. Back-to-back call/ret on consecutive cycles are legal.
- A ret on the edge after a call returns the address pushed by that call.
- clr asserted mid-sequence (any other inputs high) overrides all commands on that edge.
- An `oe` toggle affects `out` combinationally, with no clock dependency and no effect on state.
- Inputs are sampled only at the rising edge. There is no handshake, and the control unit guarantees one-hot command intent.

## Test plan
- Reset/increment, WIDTH=4: clr, then 17 cycles of inc → pc 0,1,…,15,0. out follows with oe=1 and is z when oe=0.
- Absolute/relative jump, WIDTH=4: pc=5. jmp rel=0 in=0xC → pc=12. Then jmp rel=1 in=0xE (−2) → pc=10. Then jmp rel=1 in=0x7 → pc=1 (wrap).
- Call/return nesting, DEPTH=2: pc=3, call in=8 → pc=8, sp=1. Call in=0xA → pc=10, sp=2, stk_full=1. ret → pc=9, sp=1. ret → pc=4, sp=0, stk_empty=1, stk_err=0.
- Overflow/underflow, DEPTH=2: with sp=2, call in=1 → pc unchanged, sp=2, stk_err=1. clr → stk_err=0. Then ret with sp=0 → pc unchanged, stk_err=1. A following inc still advances pc.
- Priority: with jmp=call=ret=inc=1 and in=6 → pc=6, sp unchanged. With call=ret=inc=1 and in=2 → push occurs, pc=2. With clr and all others =1 → pc=0, sp=0.
- Call at wrap, WIDTH=4: pc=15, call in=4 → pushed value 0. ret → pc=0.

Source files
------------

// File: rtl/prog_counter_stack.sv
// prog_counter_stack: program counter with absolute/relative jump and a
// hardware call/return stack.
// Ports:
//   clk, clr       clock and synchronous active-high clear
//   in             jump/call target, or two's-complement offset when rel=1
//   oe             enables the tri-state bus output 'out'
//   jmp, rel       jump (relative when rel=1)
//   call, ret      push return address and load 'in' / pop into pc
//   inc            increment pc
//   out            pc onto the shared bus when oe=1, else high-z
//   pc             current counter value, always driven
//   sp             number of valid stack entries
//   stk_full       sp == DEPTH
//   stk_empty      sp == 0
//   stk_err        sticky overflow/underflow flag, cleared only by clr
module prog_counter_stack #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned SPW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] in,
    input  logic             oe,
    input  logic             jmp,
    input  logic             rel,
    input  logic             call,
    input  logic             ret,
    input  logic             inc,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] pc,
    output logic [SPW-1:0]   sp,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_err
);

    // Width of a stack-array index; a one-entry stack still needs one bit.
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] pc_plus1;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;

    assign pc_plus1 = pc + WIDTH'(1);
    // Indices are only used when the stack is known not full / not empty,
    // so truncating sp to the array index width loses nothing.
    assign push_idx = AW'(sp);
    assign pop_idx  = AW'(sp - SPW'(1));

    // Status decodes of the stack pointer.
    assign stk_full  = (sp == SPW'(DEPTH));
    assign stk_empty = (sp == '0);

    // Bus driver: purely combinational on oe.
    assign out = oe ? pc : {WIDTH{1'bz}};

    // Counter, pointer and error flag; fixed priority clr > jmp > call > ret > inc.
    always_ff @(posedge clk) begin
        if (clr) begin
            pc      <= '0;
            sp      <= '0;
            stk_err <= 1'b0;
        end else if (jmp) begin
            // Adding the WIDTH-bit two's-complement offset modulo 2^WIDTH
            // is the same as adding its sign extension.
            pc <= rel ? (pc + in) : in;
        end else if (call) begin
            if (stk_full) begin
                stk_err <= 1'b1;
            end else begin
                stack[push_idx] <= pc_plus1;
                sp              <= sp + SPW'(1);
                pc              <= in;
            end
        end else if (ret) begin
            if (stk_empty) begin
                stk_err <= 1'b1;
            end else begin
                pc <= stack[pop_idx];
                sp <= sp - SPW'(1);
            end
        end else if (inc) begin
            pc <= pc_plus1;
        end
    end

endmodule
